// File: rtl/hilo_muldiv_if.sv
// Handshake and data bundle between the EX stage and the HI/LO multiply unit.
// master = pipeline side (drives requests), slave = multiply unit.
//
// start       : request qualifying alu_control
// alu_control : 6-bit operation code
// rs_val      : operand A, also the MTHI/MTLO source
// rt_val      : operand B
// kill        : abort an in-flight multiply, or suppress a same-cycle start
// busy        : multiply in flight
// stall       : start & busy, pipeline must hold EX
// done        : one-cycle pulse while HI/LO is being written by a multiply
// illegal     : one-cycle pulse after a start with an unsupported code
// mf_data     : HI (MFHI) or LO (MFLO) when requested, else 0
// hi, lo      : architectural HI/LO registers
interface hilo_muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [5:0]      alu_control;
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;
    logic            kill;
    logic            busy;
    logic            stall;
    logic            done;
    logic            illegal;
    logic [XLEN-1:0] mf_data;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport master (
        output start,
        output alu_control,
        output rs_val,
        output rt_val,
        output kill,
        input  busy,
        input  stall,
        input  done,
        input  illegal,
        input  mf_data,
        input  hi,
        input  lo
    );

    modport slave (
        input  start,
        input  alu_control,
        input  rs_val,
        input  rt_val,
        input  kill,
        output busy,
        output stall,
        output done,
        output illegal,
        output mf_data,
        output hi,
        output lo
    );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle multiply / multiply-accumulate engine owning the HI/LO pair.
// Ports: clk, rst (sync, active-high), bus (hilo_muldiv_if.slave).
//
// Signed operands are converted to magnitudes, multiplied with an unsigned
// shift-add array retiring BPC multiplier bits per cycle, and the sign is
// reapplied to the full 2*XLEN product in the FINISH cycle.
module hilo_muldiv_unit #(
    parameter int XLEN = 32,
    parameter int BPC  = 1
) (
    input logic          clk,
    input logic          rst,
    hilo_muldiv_if.slave bus
);

    localparam int N  = XLEN / BPC;
    localparam int CW = $clog2(N + 1);
    localparam int PW = 2 * XLEN;

    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_MADD  = 6'b011100;
    localparam logic [5:0] OP_MADDU = 6'b011101;
    localparam logic [5:0] OP_MFHI  = 6'b010000;
    localparam logic [5:0] OP_MFLO  = 6'b010010;
    localparam logic [5:0] OP_MTHI  = 6'b010001;
    localparam logic [5:0] OP_MTLO  = 6'b010011;

    if (XLEN < 4 || (XLEN % 2) != 0 ||
        !(BPC == 1 || BPC == 2 || BPC == 4) ||
        (XLEN % BPC) != 0) begin : g_bad_params
        $error("hilo_muldiv_unit: unsupported XLEN/BPC");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic [XLEN-1:0] mplier;
    logic [PW-1:0]   mcand;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   acc_nx;
    logic [PW-1:0]   prod;
    logic [PW-1:0]   result;
    logic [CW-1:0]   cnt;
    logic            neg;
    logic            accum;
    logic            illegal_q;

    logic is_mul;
    logic is_sgn;
    logic is_acc;
    logic is_mthi;
    logic is_mtlo;
    logic is_mfhi;
    logic is_mflo;
    logic legal;
    logic accept;
    logic last;

    logic [XLEN-1:0] rs_mag;
    logic [XLEN-1:0] rt_mag;

    // Opcode decode
    always_comb begin
        is_mul  = 1'b0;
        is_sgn  = 1'b0;
        is_acc  = 1'b0;
        is_mthi = 1'b0;
        is_mtlo = 1'b0;
        is_mfhi = 1'b0;
        is_mflo = 1'b0;
        case (bus.alu_control)
            OP_MULT: begin
                is_mul = 1'b1;
                is_sgn = 1'b1;
            end
            OP_MULTU: begin
                is_mul = 1'b1;
            end
            OP_MADD: begin
                is_mul = 1'b1;
                is_sgn = 1'b1;
                is_acc = 1'b1;
            end
            OP_MADDU: begin
                is_mul = 1'b1;
                is_acc = 1'b1;
            end
            OP_MFHI: is_mfhi = 1'b1;
            OP_MFLO: is_mflo = 1'b1;
            OP_MTHI: is_mthi = 1'b1;
            OP_MTLO: is_mtlo = 1'b1;
            default: ;
        endcase
    end

    assign legal = is_mul | is_mthi | is_mtlo | is_mfhi | is_mflo;

    // A request only takes effect in IDLE and when not flushed alongside.
    assign accept = bus.start & ~bus.kill & (state == IDLE);
    assign last   = (cnt == CW'(N - 1));

    // |x| fits in XLEN bits unsigned, including the most negative value.
    assign rs_mag = (is_sgn && bus.rs_val[XLEN-1]) ? -bus.rs_val : bus.rs_val;
    assign rt_mag = (is_sgn && bus.rt_val[XLEN-1]) ? -bus.rt_val : bus.rt_val;

    // Shift-add step: fold in BPC multiplier bits against the shifted
    // multiplicand.
    always_comb begin
        acc_nx = acc;
        for (int j = 0; j < BPC; j++) begin
            if (mplier[j]) begin
                acc_nx = acc_nx + (mcand << j);
            end
        end
    end

    assign prod   = neg ? -acc : acc;
    assign result = accum ? ({hi_q, lo_q} + prod) : prod;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept && is_mul) begin
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (bus.kill) begin
                    state_nx = IDLE;
                end else if (last) begin
                    state_nx = FINISH;
                end
            end
            FINISH: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        bus.busy    = (state != IDLE);
        bus.done    = (state == FINISH) & ~bus.kill;
        bus.stall   = bus.start & (state != IDLE);
        bus.illegal = illegal_q;
        bus.hi      = hi_q;
        bus.lo      = lo_q;
        bus.mf_data = '0;
        if (bus.start && is_mfhi) begin
            bus.mf_data = hi_q;
        end else if (bus.start && is_mflo) begin
            bus.mf_data = lo_q;
        end
    end

    // Datapath and HI/LO
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q      <= '0;
            lo_q      <= '0;
            mplier    <= '0;
            mcand     <= '0;
            acc       <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
            accum     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= accept & ~legal;
            case (state)
                IDLE: begin
                    if (accept && is_mul) begin
                        mcand  <= {{XLEN{1'b0}}, rs_mag};
                        mplier <= rt_mag;
                        neg    <= is_sgn &
                                  (bus.rs_val[XLEN-1] ^ bus.rt_val[XLEN-1]);
                        accum  <= is_acc;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                    if (accept && is_mthi) begin
                        hi_q <= bus.rs_val;
                    end
                    if (accept && is_mtlo) begin
                        lo_q <= bus.rs_val;
                    end
                end
                BUSY: begin
                    if (!bus.kill) begin
                        acc    <= acc_nx;
                        mcand  <= mcand << BPC;
                        mplier <= mplier >> BPC;
                        cnt    <= cnt + CW'(1);
                    end
                end
                FINISH: begin
                    if (!bus.kill) begin
                        {hi_q, lo_q} <= result;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: one BPC=1 and one BPC=4 instance
// share stimulus, selected by sel; a monitor checks done/illegal results.
module tb_hilo_muldiv_unit;

    localparam int XLEN = 32;

    localparam logic [5:0] MULT  = 6'b011000;
    localparam logic [5:0] MULTU = 6'b011001;
    localparam logic [5:0] MADD  = 6'b011100;
    localparam logic [5:0] MADDU = 6'b011101;
    localparam logic [5:0] MFHI  = 6'b010000;
    localparam logic [5:0] MFLO  = 6'b010010;
    localparam logic [5:0] MTHI  = 6'b010001;
    localparam logic [5:0] MTLO  = 6'b010011;

    typedef struct {
        bit          is_ill;
        logic [63:0] hl;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  code;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        kill;
    int          sel;

    int tests = 0;
    int fails = 0;

    exp_t        q[$];
    logic [63:0] mhl[2];
    logic [5:0]  ops[10];

    always #5 clk = ~clk;

    hilo_muldiv_if #(.XLEN(XLEN)) b1 ();
    hilo_muldiv_if #(.XLEN(XLEN)) b4 ();

    hilo_muldiv_unit #(.XLEN(XLEN), .BPC(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    hilo_muldiv_unit #(.XLEN(XLEN), .BPC(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (b4)
    );

    assign b1.start       = start & (sel == 0);
    assign b1.kill        = kill & (sel == 0);
    assign b1.alu_control = code;
    assign b1.rs_val      = rs;
    assign b1.rt_val      = rt;
    assign b4.start       = start & (sel == 1);
    assign b4.kill        = kill & (sel == 1);
    assign b4.alu_control = code;
    assign b4.rs_val      = rs;
    assign b4.rt_val      = rt;

    logic        busy_m, stall_m, done_m, ill_m;
    logic [31:0] mf_m, hi_m, lo_m;

    assign busy_m  = sel ? b4.busy    : b1.busy;
    assign stall_m = sel ? b4.stall   : b1.stall;
    assign done_m  = sel ? b4.done    : b1.done;
    assign ill_m   = sel ? b4.illegal : b1.illegal;
    assign mf_m    = sel ? b4.mf_data : b1.mf_data;
    assign hi_m    = sel ? b4.hi      : b1.hi;
    assign lo_m    = sel ? b4.lo      : b1.lo;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (sel=%0d t=%0t)",
                     nm, act, exp, sel, $time);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural definition.
    function automatic logic [63:0] model(input logic [5:0] c,
                                          input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [63:0] cur);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0]        p;
        sa = $signed(a);
        sb = $signed(b);
        if (c == MULT || c == MADD) p = sa * sb;
        else p = {32'b0, a} * {32'b0, b};
        if (c == MADD || c == MADDU) return cur + p;
        return p;
    endfunction

    function automatic bit is_mul(input logic [5:0] c);
        return c == MULT || c == MULTU || c == MADD || c == MADDU;
    endfunction

    // Monitor: pops an expectation whenever the DUT reports a result.
    always @(negedge clk) begin
        if (!rst) begin
            if (done_m) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("done_kind", 0, 64'(e.is_ill));
                    @(posedge clk);
                    #1;
                    chk("hilo_result", {hi_m, lo_m}, e.hl);
                end
            end else if (ill_m) begin
                if (q.size() == 0) begin
                    chk("unexpected_illegal", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("illegal_kind", 1, 64'(e.is_ill));
                end
            end
        end
    end

    // Called at a negedge; returns at a negedge with the unit idle.
    task automatic issue(input logic [5:0] c, input logic [31:0] a,
                         input logic [31:0] b);
        int cyc;
        exp_t e;
        start = 1'b1;
        code  = c;
        rs    = a;
        rt    = b;
        #1;
        chk("stall_idle", 64'(stall_m), 0);
        if (is_mul(c)) begin
            mhl[sel] = model(c, a, b, mhl[sel]);
            e.is_ill = 1'b0;
            e.hl     = mhl[sel];
            q.push_back(e);
        end else if (c == MFHI) begin
            chk("mfhi", 64'(mf_m), 64'(mhl[sel][63:32]));
        end else if (c == MFLO) begin
            chk("mflo", 64'(mf_m), 64'(mhl[sel][31:0]));
        end else if (c == MTHI) begin
            mhl[sel][63:32] = a;
        end else if (c == MTLO) begin
            mhl[sel][31:0] = a;
        end else begin
            e.is_ill = 1'b1;
            e.hl     = '0;
            q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        if (is_mul(c)) begin
            cyc = 0;
            while (busy_m && cyc < 200) begin
                cyc++;
                @(negedge clk);
            end
            chk("latency", 64'(cyc), sel ? 64'd9 : 64'd33);
        end else if (c == MTHI || c == MTLO) begin
            chk("mt_write", {hi_m, lo_m}, mhl[sel]);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mhl[0] = '0;
        mhl[1] = '0;
        q.delete();
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h0;
            3: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        exp_t e;
        ops = '{MULT, MULTU, MADD, MADDU, MFHI, MFLO, MTHI, MTLO,
                6'b100000, 6'b111111};
        start = 1'b0;
        kill  = 1'b0;
        code  = '0;
        rs    = '0;
        rt    = '0;
        sel   = 0;
        rst   = 1'b1;
        @(negedge clk);
        do_reset();

        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            chk("rst_hilo", {hi_m, lo_m}, 0);
            chk("rst_flags", {busy_m, done_m, ill_m, stall_m}, 0);
            chk("mf_idle", 64'(mf_m), 0);
        end
        sel = 0;
        @(negedge clk);

        issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("plan_multu", {hi_m, lo_m}, 64'hFFFFFFFE_00000001);
        issue(MULT, 32'hFFFF_FFFD, 32'd5);
        chk("plan_mult_neg", {hi_m, lo_m}, 64'hFFFFFFFF_FFFFFFF1);
        issue(MULT, 32'h8000_0000, 32'h8000_0000);
        chk("plan_mult_min", {hi_m, lo_m}, 64'h40000000_00000000);
        issue(MTHI, 32'd0, 32'd0);
        issue(MTLO, 32'd10, 32'd0);
        issue(MADD, 32'hFFFF_FFFE, 32'd3);
        chk("plan_madd", {hi_m, lo_m}, 64'd4);
        issue(MTHI, 32'hFFFF_FFFF, 32'd0);
        issue(MTLO, 32'hFFFF_FFFF, 32'd0);
        issue(MADDU, 32'd1, 32'd1);
        chk("plan_maddu_wrap", {hi_m, lo_m}, 64'd0);

        // Requests while busy are stalled and dropped.
        start = 1'b1;
        code  = MULTU;
        rs    = 32'd7;
        rt    = 32'd6;
        mhl[0] = 64'd42;
        e.is_ill = 1'b0;
        e.hl     = 64'd42;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        code  = MFLO;
        #1;
        chk("stall_mflo", 64'(stall_m), 1);
        @(negedge clk);
        code = MTLO;
        rs   = 32'h5555;
        #1;
        chk("stall_mtlo", 64'(stall_m), 1);
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (busy_m && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        chk("stall_busy_end", 64'(busy_m), 0);
        issue(MFLO, 32'd0, 32'd0);
        issue(MFHI, 32'd0, 32'd0);

        // Kill mid-multiply leaves HI/LO alone and produces no done.
        issue(MTHI, 32'h11, 32'd0);
        issue(MTLO, 32'h22, 32'd0);
        start = 1'b1;
        code  = MULT;
        rs    = 32'h1234;
        rt    = 32'h5678;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        chk("kill_busy", 64'(busy_m), 0);
        repeat (40) @(negedge clk);
        chk("kill_hilo", {hi_m, lo_m}, 64'h11_00000022);

        // Kill together with start suppresses the request.
        start = 1'b1;
        kill  = 1'b1;
        code  = MTHI;
        rs    = 32'hDEAD;
        @(negedge clk);
        start = 1'b0;
        kill  = 1'b0;
        chk("kill_start_mt", {hi_m, lo_m}, 64'h11_00000022);
        issue(6'b100000, 32'd0, 32'd0);
        @(negedge clk);

        for (int s = 0; s < 2; s++) begin
            sel = s;
            if (s == 1) begin
                issue(MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
                issue(6'b100000, 32'd0, 32'd0);
            end
            for (int i = 0; i < 30; i++) begin
                issue(ops[$urandom_range(0, 9)], rnd_val(), rnd_val());
            end
        end

        // Reset mid-multiply drops it.
        sel   = 0;
        start = 1'b1;
        code  = MULT;
        rs    = 32'h77;
        rt    = 32'h99;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        chk("rst_mid_hilo", {hi_m, lo_m}, 0);
        chk("rst_mid_flags", {busy_m, done_m, ill_m}, 0);
        rst = 1'b0;
        mhl[0] = '0;
        mhl[1] = '0;
        repeat (40) @(negedge clk);
        chk("rst_mid_quiet", {hi_m, lo_m, 31'b0, busy_m}, 0);

        repeat (4) @(negedge clk);
        chk("sb_empty", 64'(q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
